// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: arbitrated shared double-dabble binary-to-BCD engine, one bit per clock.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module bcd_convert_arbiter #(
   parameter int NREQ = 2,
   parameter int BIN_W = 8,
   parameter int DIGITS = 3,
   localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*BIN_W-1:0]   bin,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    done,
   output logic [IDW-1:0]          done_id,
   output logic [DIGITS*4-1:0]     bcd
);
   localparam int AW = DIGITS * 4;
   localparam int CW = BIN_W > 1 ? $clog2(BIN_W) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] acc_q, acc_d, acc_adj, acc_sh;
   logic [BIN_W-1:0] op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IDW-1:0] id_q, id_d, done_id_q, done_id_d, win;
   logic [AW-1:0] bcd_q, bcd_d;
   logic any_req;
`ifdef RR_ARB_EN
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0] rot;
   int sh, off;
   // Rotate so the search begins just past the last winner, then map back.
   always_comb begin
      sh = int'(ptr_q) + 1;
      rot = NREQ'({req, req} >> sh);
      off = 0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (rot[i]) off = i;
      any_req = |req;
      win = IDW'((off + sh) % NREQ);
      ptr_d = gnt != '0 ? win : ptr_q;
   end
`else
   always_comb begin
      any_req = |req;
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[i]) win = IDW'(i);
   end
`endif
   always_comb begin
      acc_adj = acc_q;
      for (int d = 0; d < DIGITS; d++)
         acc_adj[d*4 +: 4] = acc_q[d*4 +: 4] >= 4'd5 ? acc_q[d*4 +: 4] + 4'd3 : acc_q[d*4 +: 4];
      acc_sh = {acc_adj[AW-2:0], op_q[BIN_W-1]};
   end
   assign gnt = (rst_n && state_q == IDLE && any_req) ? NREQ'(1) << win : '0;
   assign busy = state_q != IDLE || gnt != '0;
   assign done = state_q == DONE;
   assign bcd = bcd_q;
   assign done_id = done_id_q;
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      op_d = op_q;
      cnt_d = cnt_q;
      id_d = id_q;
      bcd_d = bcd_q;
      done_id_d = done_id_q;
      case (state_q)
         IDLE: if (any_req) begin
            state_d = SHIFT;
            op_d = bin[int'(win)*BIN_W +: BIN_W];
            id_d = win;
            acc_d = '0;
            cnt_d = '0;
         end
         SHIFT: begin
            acc_d = acc_sh;
            op_d = op_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(BIN_W - 1)) begin
               state_d = DONE;
               bcd_d = acc_sh;
               done_id_d = id_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q <= '0;
         op_q <= '0;
         cnt_q <= '0;
         id_q <= '0;
         bcd_q <= '0;
         done_id_q <= '0;
`ifdef RR_ARB_EN
         ptr_q <= IDW'(NREQ - 1);
`endif
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         op_q <= op_d;
         cnt_q <= cnt_d;
         id_q <= id_d;
         bcd_q <= bcd_d;
         done_id_q <= done_id_d;
`ifdef RR_ARB_EN
         ptr_q <= ptr_d;
`endif
      end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: directed vectors for the shared BCD converter, both arbitration builds.
module tb_bcd_convert_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] req;
   logic [15:0] bin;
   logic [1:0] gnt;
   logic busy, done;
   logic [0:0] done_id;
   logic [11:0] bcd;
   int n_vec = 0, n_err = 0;
`ifdef RR_ARB_EN
   int exp_seq[5] = '{0, 1, 0, 1, 1};
`else
   int exp_seq[5] = '{0, 0, 0, 1, 1};
`endif
   always #5 clk = ~clk;
   bcd_convert_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req(req), .bin(bin), .gnt(gnt),
      .busy(busy), .done(done), .done_id(done_id), .bcd(bcd)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   // Request on channel k, then scramble its operand to v2 right after capture.
   task automatic conv(input int k, input logic [7:0] v, input logic [7:0] v2, input logic [11:0] exp);
      int t = 0;
      @(negedge clk);
      bin[k*8 +: 8] = v;
      req[k] = 1'b1;
      #1;
      while (gnt[k] !== 1'b1 && t < 30) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("gnt_seen", 32'(t < 30), 32'd1);
      chk("gnt_onehot", 32'(gnt), 32'(1 << k));
      chk("busy_at_gnt", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      req[k] = 1'b0;
      bin[k*8 +: 8] = v2;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         chk("busy", 32'(busy), 32'd1);
         chk("done", 32'(done), 32'(c == 9));
      end
      chk("bcd", 32'(bcd), 32'(exp));
      chk("done_id", 32'(done_id), 32'(k));
      @(negedge clk);
      chk("busy_drop", 32'(busy), 32'd0);
      chk("done_clr", 32'(done), 32'd0);
      chk("bcd_hold", 32'(bcd), 32'(exp));
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      int ng, last, lastid;
      rst_n = 1'b0;
      req = '0;
      bin = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_id", 32'(done_id), 32'd0);
      rst_n = 1'b1;
      conv(0, 8'd255, 8'd255, 12'h255);
      conv(1, 8'd0, 8'd0, 12'h000);
      conv(1, 8'd99, 8'd99, 12'h099);
      conv(1, 8'd100, 8'd100, 12'h100);
      // Contention: both held; req[0] withdrawn mid-run.
      bin = {8'd22, 8'd11};
      req = 2'b11;
      ng = 0;
      last = -1;
      lastid = 0;
      for (int c = 0; c < 42; c++) begin
         #1;
         chk("gnt_vs_done", 32'(gnt != 2'b00 && done), 32'd0);
         if (done) begin
            chk("arb_done_id", 32'(done_id), 32'(lastid));
            chk("arb_bcd", 32'(bcd), lastid == 1 ? 32'h022 : 32'h011);
         end
         if (gnt != 2'b00) begin
            if (ng < 5) chk("arb_order", 32'(gnt), 32'(1 << exp_seq[ng]));
            if (last >= 0) chk("arb_gap", 32'(c - last), 32'd10);
            lastid = gnt[1] ? 1 : 0;
            last = c;
            ng++;
         end
         if (c == 25) req[0] = 1'b0;
         if (c == 41) req = '0;
         @(negedge clk);
      end
      chk("arb_count", 32'(ng), 32'd5);
      repeat (10) @(negedge clk);
      conv(0, 8'd200, 8'd7, 12'h200);
      // Reset mid-conversion drops the job.
      @(negedge clk);
      bin[7:0] = 8'd123;
      req[0] = 1'b1;
      #1;
      chk("pre_rst_gnt", 32'(gnt), 32'd1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_bcd", 32'(bcd), 32'd0);
      chk("mid_rst_id", 32'(done_id), 32'd0);
      repeat (2) @(negedge clk);
      req = '0;
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("post_rst_no_done", 32'(done), 32'd0);
      end
      conv(0, 8'd42, 8'd42, 12'h042);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
